// File: rtl/mem_arbiter_if.sv
// Bus bundle between two rcpu-style masters, the arbiter and the shared memory port.
// slave = arbiter side, master = the agent driving the requests and the memory responses.
interface mem_arbiter_if #(
   parameter int M = 16,
   parameter int N = 32
);
   logic [N-1:0] p0_addr, p1_addr;
   logic [M-1:0] p0_wdata, p1_wdata;
   logic         p0_re, p0_we, p1_re, p1_we;
   logic         p0_ready, p1_ready, p0_err, p1_err;
   logic [M-1:0] rdata;
   logic [N-1:0] mem_addr;
   logic [M-1:0] mem_wdata;
   logic         mem_re, mem_we;
   logic [M-1:0] mem_rdata;
   logic         mem_ready;
   logic         grant, busy;

   modport slave (
      input  p0_addr, p1_addr, p0_wdata, p1_wdata, p0_re, p0_we, p1_re, p1_we,
      input  mem_rdata, mem_ready,
      output p0_ready, p1_ready, p0_err, p1_err, rdata,
      output mem_addr, mem_wdata, mem_re, mem_we, grant, busy
   );

   modport master (
      output p0_addr, p1_addr, p0_wdata, p1_wdata, p0_re, p0_we, p1_re, p1_we,
      output mem_rdata, mem_ready,
      input  p0_ready, p1_ready, p0_err, p1_err, rdata,
      input  mem_addr, mem_wdata, mem_re, mem_we, grant, busy
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master arbiter for a single memory port: one transaction per grant, round-robin or
// fixed priority, with a watchdog that completes a stalled access with an error flag.
module mem_arbiter #(
   parameter int M         = 16,
   parameter int N         = 32,
   parameter int FIXED_PRI = 0,
   parameter int TIMEOUT   = 255
) (
   input logic          clk,
   input logic          rst,
   mem_arbiter_if.slave bus
);
   localparam logic [1:0]  IDLE = 2'd0;
   localparam logic [1:0]  BUSY = 2'd1;
   localparam logic [1:0]  DONE = 2'd2;
   localparam logic [15:0] WDOG_LIM = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

   logic [1:0]  state;
   logic        grant, last;
   logic [15:0] wdog;
   logic        req0, req1, gReq, inBusy, abort, winner;

   always_comb begin
      req0   = bus.p0_re | bus.p0_we;
      req1   = bus.p1_re | bus.p1_we;
      gReq   = grant ? req1 : req0;
      inBusy = (state == BUSY);
      // abandon takes precedence: the watchdog only fires while the master still asks
      abort  = inBusy && !bus.mem_ready && gReq && (TIMEOUT != 0) && (wdog == WDOG_LIM);
      winner = (req0 && req1) ? ((FIXED_PRI != 0) ? 1'b0 : ~last) : req1;
   end

   assign bus.busy      = inBusy;
   assign bus.grant     = grant;
   assign bus.mem_re    = inBusy & (grant ? bus.p1_re : bus.p0_re);
   assign bus.mem_we    = inBusy & (grant ? bus.p1_we : bus.p0_we);
   assign bus.mem_addr  = inBusy ? (grant ? bus.p1_addr : bus.p0_addr) : '0;
   assign bus.mem_wdata = inBusy ? (grant ? bus.p1_wdata : bus.p0_wdata) : '0;
   assign bus.rdata     = inBusy ? bus.mem_rdata : '0;
   assign bus.p0_ready  = inBusy & ~grant & (bus.mem_ready | abort);
   assign bus.p1_ready  = inBusy &  grant & (bus.mem_ready | abort);
   assign bus.p0_err    = ~grant & abort;
   assign bus.p1_err    =  grant & abort;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         grant <= 1'b0;
         last  <= 1'b1;
         wdog  <= '0;
      end else begin
         case (state)
            IDLE: if (req0 || req1) begin
               grant <= winner;
               wdog  <= '0;
               state <= BUSY;
            end
            BUSY: if (bus.mem_ready || abort) begin
               last  <= grant;
               state <= DONE;
            end else if (!gReq) begin
               last  <= grant;
               state <= IDLE;
            end else if (wdog != 16'hFFFF) begin
               wdog <= wdog + 16'd1;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized check of two arbiter builds (round-robin with watchdog 8, fixed priority without
// watchdog) against a transaction-level model; includes reset state and a mid-access reset.
module tb_mem_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [31:0] addrS [2][2];
   logic [15:0] wdataS[2][2];
   logic        reS   [2][2];
   logic        weS   [2][2];
   logic        memReady[2];
   logic [15:0] memRdata[2];

   logic [1:0]  busyO, grantO, memReO, memWeO, rdy0O, rdy1O, err0O, err1O;
   logic [31:0] memAddrO [2];
   logic [15:0] memWdataO[2];
   logic [15:0] rdataO   [2];

   mem_arbiter_if #(.M(16), .N(32)) bus[2] ();

   mem_arbiter #(.M(16), .N(32), .FIXED_PRI(0), .TIMEOUT(8)) dutRr (
      .clk(clk), .rst(rst), .bus(bus[0]));
   mem_arbiter #(.M(16), .N(32), .FIXED_PRI(1), .TIMEOUT(0)) dutFix (
      .clk(clk), .rst(rst), .bus(bus[1]));

   for (genvar i = 0; i < 2; i++) begin : g_bus
      assign bus[i].p0_addr   = addrS[i][0];
      assign bus[i].p1_addr   = addrS[i][1];
      assign bus[i].p0_wdata  = wdataS[i][0];
      assign bus[i].p1_wdata  = wdataS[i][1];
      assign bus[i].p0_re     = reS[i][0];
      assign bus[i].p0_we     = weS[i][0];
      assign bus[i].p1_re     = reS[i][1];
      assign bus[i].p1_we     = weS[i][1];
      assign bus[i].mem_ready = memReady[i];
      assign bus[i].mem_rdata = memRdata[i];
      assign busyO[i]     = bus[i].busy;
      assign grantO[i]    = bus[i].grant;
      assign memReO[i]    = bus[i].mem_re;
      assign memWeO[i]    = bus[i].mem_we;
      assign rdy0O[i]     = bus[i].p0_ready;
      assign rdy1O[i]     = bus[i].p1_ready;
      assign err0O[i]     = bus[i].p0_err;
      assign err1O[i]     = bus[i].p1_err;
      assign memAddrO[i]  = bus[i].mem_addr;
      assign memWdataO[i] = bus[i].mem_wdata;
      assign rdataO[i]    = bus[i].rdata;
   end

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // model: who owns the port (-1 none), cycles spent waiting, last served, bubble pending
   int fixedPri[2] = '{0, 1};
   int tmo[2]      = '{8, 0};
   int owner[2], waitCnt[2], lastSrv[2];
   bit cool[2];
   bit act[2][2], readySeen[2][2];

   task automatic modelReset();
      for (int d = 0; d < 2; d++) begin
         owner[d] = -1; waitCnt[d] = 0; lastSrv[d] = 1; cool[d] = 0;
         for (int p = 0; p < 2; p++) begin
            act[d][p] = 0; readySeen[d][p] = 0;
            reS[d][p] = 0; weS[d][p] = 0; addrS[d][p] = '0; wdataS[d][p] = '0;
         end
         memReady[d] = 0; memRdata[d] = '0;
      end
   endtask

   task automatic chkQuiet(input int d, input string why);
      chk($sformatf("%s_busy%0d", why, d), 64'(busyO[d]), 0);
      chk($sformatf("%s_grant%0d", why, d), 64'(grantO[d]), 0);
      chk($sformatf("%s_memre%0d", why, d), 64'(memReO[d]), 0);
      chk($sformatf("%s_memwe%0d", why, d), 64'(memWeO[d]), 0);
      chk($sformatf("%s_rdy%0d", why, d), 64'({rdy0O[d], rdy1O[d], err0O[d], err1O[d]}), 0);
   endtask

   task automatic newReq(input int d, input int p);
      int k;
      k = $urandom_range(0, 9);
      reS[d][p]    = (k < 5) || (k == 9);
      weS[d][p]    = (k >= 5);
      addrS[d][p]  = $urandom;
      wdataS[d][p] = 16'($urandom);
   endtask

   task automatic checkAndStep(input int d);
      bit rq[2];
      bit sv, to, fin;
      int g;
      for (int p = 0; p < 2; p++) rq[p] = reS[d][p] | weS[d][p];
      sv  = owner[d] >= 0;
      g   = sv ? owner[d] : 0;
      to  = sv && tmo[d] != 0 && waitCnt[d] == tmo[d] - 1 && !memReady[d] && rq[g];
      fin = sv && (memReady[d] || to);
      chk($sformatf("busy%0d", d), 64'(busyO[d]), 64'(sv));
      if (sv) chk($sformatf("grant%0d", d), 64'(grantO[d]), 64'(g));
      chk($sformatf("memre%0d", d), 64'(memReO[d]), 64'(sv && reS[d][g]));
      chk($sformatf("memwe%0d", d), 64'(memWeO[d]), 64'(sv && weS[d][g]));
      chk($sformatf("memaddr%0d", d), 64'(memAddrO[d]), sv ? 64'(addrS[d][g]) : 64'd0);
      chk($sformatf("memwdata%0d", d), 64'(memWdataO[d]), sv ? 64'(wdataS[d][g]) : 64'd0);
      chk($sformatf("p0rdy%0d", d), 64'(rdy0O[d]), 64'(fin && g == 0));
      chk($sformatf("p1rdy%0d", d), 64'(rdy1O[d]), 64'(fin && g == 1));
      chk($sformatf("p0err%0d", d), 64'(err0O[d]), 64'(to && g == 0));
      chk($sformatf("p1err%0d", d), 64'(err1O[d]), 64'(to && g == 1));
      if (fin && !to) chk($sformatf("rdata%0d", d), 64'(rdataO[d]), 64'(memRdata[d]));
      readySeen[d][0] = fin && g == 0;
      readySeen[d][1] = fin && g == 1;
      if (sv) begin
         if (fin) begin
            lastSrv[d] = g; owner[d] = -1; cool[d] = 1;
         end else if (!rq[g]) begin
            lastSrv[d] = g; owner[d] = -1;
         end else if (waitCnt[d] < 65535) begin
            waitCnt[d]++;
         end
      end else if (cool[d]) begin
         cool[d] = 0;
      end else if (rq[0] || rq[1]) begin
         owner[d]   = (rq[0] && rq[1]) ? (fixedPri[d] != 0 ? 0 : 1 - lastSrv[d]) : (rq[1] ? 1 : 0);
         waitCnt[d] = 0;
      end
   endtask

   initial begin
      int pct;
      bit didRst, postRst;
      didRst = 0; postRst = 0;
      modelReset();
      #1 rst = 1'b0;
      #2;
      for (int d = 0; d < 2; d++) chkQuiet(d, "reset");
      @(negedge clk);
      #2 rst = 1'b1;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(posedge clk);
         #1;
         case ((cyc / 150) % 4)
            0:       pct = 100;
            1:       pct = 60;
            2:       pct = 20;
            default: pct = 0;
         endcase
         for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
               if (act[d][p] && readySeen[d][p]) begin
                  act[d][p] = ($urandom_range(0, 1) == 1);
                  if (act[d][p]) newReq(d, p);
               end else if (act[d][p] && $urandom_range(0, 99) < 2) begin
                  act[d][p] = 0;
               end else if (!act[d][p] && $urandom_range(0, 99) < 30) begin
                  act[d][p] = 1;
                  newReq(d, p);
               end
               if (!act[d][p]) begin
                  reS[d][p] = 0; weS[d][p] = 0; addrS[d][p] = $urandom;
               end
            end
            memReady[d] = ($urandom_range(0, 99) < pct);
            memRdata[d] = 16'($urandom);
         end
         if (postRst) begin
            // both ports asked right after reset: port 0 must win on either build
            for (int d = 0; d < 2; d++) begin
               chk($sformatf("postrst_busy%0d", d), 64'(busyO[d]), 1);
               chk($sformatf("postrst_grant%0d", d), 64'(grantO[d]), 0);
            end
            postRst = 0;
         end
         if (!didRst && cyc >= 1500 && owner[0] >= 0) begin
            didRst = 1;
            #1 rst = 1'b0;
            #1;
            for (int d = 0; d < 2; d++) chkQuiet(d, "midrst");
            modelReset();
            for (int d = 0; d < 2; d++) begin
               for (int p = 0; p < 2; p++) begin
                  act[d][p] = 1; reS[d][p] = 1; addrS[d][p] = 32'h1000 + 32'(p);
               end
            end
            #1 rst = 1'b1;
            postRst = 1;
         end
         @(negedge clk);
         for (int d = 0; d < 2; d++) checkAndStep(d);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
